gw_dpb_port_arbiter: RTL and testbench

//  Shares FPGA-side port B of the block-RAM mailbox (Gowin_DPB) between NUM_REQ fabric requesters.

---
 rtl/gw_dpb_arb_pkg.sv | 30 +++
 rtl/gw_rr_picker.sv | 44 ++++
 rtl/gw_dpb_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_gw_dpb_port_arbiter.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gw_dpb_arb_pkg.sv
// -----------------------------------------------------------------------------
// gw_dpb_arb_pkg
// Shared types and helpers for the Gowin DPB port-B arbiter.
//   dpb_arb_state_t    : arbiter FSM state (IDLE between grants, GRANT while owned)
//   DPB_RD_LATENCY_DEF : read latency of a DPB with output register enabled (oce=1)
//   clog2()            : ceiling log2 usable in parameter/localparam expressions
// -----------------------------------------------------------------------------
package gw_dpb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } dpb_arb_state_t;

    localparam int unsigned DPB_RD_LATENCY_DEF = 2;

    // Number of bits needed to index 'value' distinct items; 0 for value <= 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned remain;
        result = 0;
        remain = (value > 0) ? value - 1 : 0;
        while (remain > 0) begin
            result = result + 1;
            remain = remain >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/gw_rr_picker.sv
// -----------------------------------------------------------------------------
// gw_rr_picker
// Combinational round-robin pick: the first asserted request strictly after
// i_ptr, wrapping, so the requester at i_ptr itself is considered last.
// Ports:
//   i_req    : request vector
//   i_ptr    : index of the most recently served requester
//   o_grant  : one-hot pick (all zero when nothing requests)
//   o_idx    : index of the pick (0 when nothing requests)
//   o_any    : at least one request present
// -----------------------------------------------------------------------------
module gw_rr_picker
    import gw_dpb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        int unsigned cand;
        cand    = 0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Walk candidates in rotation order ptr+1 .. ptr+NUM_REQ; first hit wins.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(i_ptr) + k) % NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!o_any && (cand == j) && i_req[j]) begin
                    o_any      = 1'b1;
                    o_grant[j] = 1'b1;
                    o_idx      = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/gw_dpb_port_arbiter.sv
// -----------------------------------------------------------------------------
// gw_dpb_port_arbiter
// Shares FPGA-side port B of the Gowin_DPB mailbox between NUM_REQ requesters.
// Round-robin grants with a bubble cycle between grants and a burst cap of
// MAX_BURST beats; the owner's beat is driven straight onto the RAM port and
// read data is returned, tagged to its issuer, RD_LATENCY cycles later.
// Ports:
//   i_fpga_clk, i_fpga_rst_n       : clock, synchronous active-low reset
//   i_req_valid/wren/last          : per-requester beat qualifiers
//   i_req_addr, i_req_wdata        : packed per-requester address / write data
//   o_req_ready                    : one-hot accept (valid & ready = beat taken)
//   o_rsp_valid, o_rsp_rdata       : one-hot read return strobe + data
//   o_ram_ce/wren/addr/wr_data     : DPB port B drive (ceb/wreb/adb/dinb)
//   i_ram_rd_data                  : DPB port B read data (doutb)
//   o_busy                         : grant held or read still in flight
// -----------------------------------------------------------------------------
module gw_dpb_port_arbiter
    import gw_dpb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned RD_LATENCY = DPB_RD_LATENCY_DEF,
    parameter int unsigned MAX_BURST  = 8
) (
    input  logic                          i_fpga_clk,
    input  logic                          i_fpga_rst_n,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_wren,
    input  logic [NUM_REQ-1:0]            i_req_last,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] i_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_wdata,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_rsp_valid,
    output logic [DATA_WIDTH-1:0]         o_rsp_rdata,
    output logic                          o_ram_ce,
    output logic                          o_ram_wren,
    output logic [ADDR_WIDTH-1:0]         o_ram_addr,
    output logic [DATA_WIDTH-1:0]         o_ram_wr_data,
    input  logic [DATA_WIDTH-1:0]         i_ram_rd_data,
    output logic                          o_busy
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = clog2(MAX_BURST + 1);

    dpb_arb_state_t     r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_owner, w_owner_nxt;
    logic [NUM_REQ-1:0] r_owner_oh, w_owner_oh_nxt;
    logic [IDX_W-1:0]   r_rr_ptr, w_rr_ptr_nxt;
    logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt;

    logic               r_pipe_vld [RD_LATENCY];
    logic [IDX_W-1:0]   r_pipe_id  [RD_LATENCY];

    logic [NUM_REQ-1:0]    w_pick_grant;
    logic [IDX_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    logic                  w_own_valid;
    logic                  w_own_wren;
    logic                  w_own_last;
    logic [ADDR_WIDTH-1:0] w_own_addr;
    logic [DATA_WIDTH-1:0] w_own_wdata;
    logic                  w_accept;
    logic                  w_tail_vld;
    logic                  w_pipe_any;

    gw_rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .i_req   (i_req_valid),
        .i_ptr   (r_rr_ptr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Select the current owner's beat.
    always_comb begin
        w_own_valid = 1'b0;
        w_own_wren  = 1'b0;
        w_own_last  = 1'b0;
        w_own_addr  = '0;
        w_own_wdata = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (r_owner == IDX_W'(j)) begin
                w_own_valid = i_req_valid[j];
                w_own_wren  = i_req_wren[j];
                w_own_last  = i_req_last[j];
                w_own_addr  = i_req_addr[j*ADDR_WIDTH +: ADDR_WIDTH];
                w_own_wdata = i_req_wdata[j*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Reset is folded in so nothing is driven or accepted while it is held.
    assign w_accept = i_fpga_rst_n && (r_state == GRANT) && w_own_valid;

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_owner_oh_nxt = r_owner_oh;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        unique case (r_state)
            IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = GRANT;
                    w_owner_nxt    = w_pick_idx;
                    w_owner_oh_nxt = w_pick_grant;
                    w_beat_cnt_nxt = '0;
                end
            end
            GRANT: begin
                if (!w_own_valid) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = r_owner;
                end else begin
                    w_beat_cnt_nxt = r_beat_cnt + CNT_W'(1);
                    if (w_own_last || (w_beat_cnt_nxt == CNT_W'(MAX_BURST))) begin
                        w_state_nxt  = IDLE;
                        w_rr_ptr_nxt = r_owner;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_fpga_clk) begin
        if (!i_fpga_rst_n) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_owner_oh <= NUM_REQ'(1);
            r_rr_ptr   <= IDX_W'(NUM_REQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_owner_oh <= w_owner_oh_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
        end
    end

    // Response pipe tracks which requester each in-flight read belongs to.
    always_ff @(posedge i_fpga_clk) begin
        if (!i_fpga_rst_n) begin
            for (int unsigned k = 0; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= 1'b0;
                r_pipe_id[k]  <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_accept && !w_own_wren;
            r_pipe_id[0]  <= r_owner;
            for (int unsigned k = 1; k < RD_LATENCY; k++) begin
                r_pipe_vld[k] <= r_pipe_vld[k-1];
                r_pipe_id[k]  <= r_pipe_id[k-1];
            end
        end
    end

    always_comb begin
        w_pipe_any = 1'b0;
        for (int unsigned k = 0; k < RD_LATENCY; k++) begin
            w_pipe_any = w_pipe_any | r_pipe_vld[k];
        end
    end

    assign w_tail_vld = i_fpga_rst_n && r_pipe_vld[RD_LATENCY-1];

    always_comb begin
        o_rsp_valid = '0;
        for (int unsigned j = 0; j < NUM_REQ; j++) begin
            if (w_tail_vld && (r_pipe_id[RD_LATENCY-1] == IDX_W'(j))) begin
                o_rsp_valid[j] = 1'b1;
            end
        end
    end

    assign o_req_ready   = w_accept ? r_owner_oh : '0;
    assign o_rsp_rdata   = i_ram_rd_data;
    assign o_ram_ce      = w_accept;
    assign o_ram_wren    = w_accept && w_own_wren;
    assign o_ram_addr    = w_accept ? w_own_addr  : '0;
    assign o_ram_wr_data = w_accept ? w_own_wdata : '0;
    assign o_busy        = i_fpga_rst_n && ((r_state == GRANT) || w_pipe_any);

endmodule

// File: tb/tb_gw_dpb_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gw_dpb_port_arbiter
// Drives directed scenarios followed by random traffic into the arbiter, with a
// behavioural DPB port-B RAM attached. A transaction-level model (owner or
// none, beats in this grant, last served requester, queue of reads with due
// cycles) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_gw_dpb_port_arbiter;

    localparam int N    = 4;
    localparam int AW   = 7;
    localparam int DW   = 16;
    localparam int LAT  = 2;
    localparam int MAXB = 8;
    localparam int IW   = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    req_valid, req_wren, req_last;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N-1:0]    req_ready, rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            ram_ce, ram_wren, busy;
    logic [AW-1:0]   ram_addr;
    logic [DW-1:0]   ram_wr_data, ram_rd_data;

    logic [AW-1:0]   a_addr  [N];
    logic [DW-1:0]   a_wdata [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW]  = a_addr[i];
            req_wdata[i*DW +: DW] = a_wdata[i];
        end
    end

    gw_dpb_port_arbiter #(
        .NUM_REQ    (N),
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RD_LATENCY (LAT),
        .MAX_BURST  (MAXB)
    ) dut (
        .i_fpga_clk    (clk),
        .i_fpga_rst_n  (rst_n),
        .i_req_valid   (req_valid),
        .i_req_wren    (req_wren),
        .i_req_last    (req_last),
        .i_req_addr    (req_addr),
        .i_req_wdata   (req_wdata),
        .o_req_ready   (req_ready),
        .o_rsp_valid   (rsp_valid),
        .o_rsp_rdata   (rsp_rdata),
        .o_ram_ce      (ram_ce),
        .o_ram_wren    (ram_wren),
        .o_ram_addr    (ram_addr),
        .o_ram_wr_data (ram_wr_data),
        .i_ram_rd_data (ram_rd_data),
        .o_busy        (busy)
    );

    // Port-B RAM: array read latched at the ce edge, then an output register.
    logic [DW-1:0] ram_mem [1<<AW];
    logic [DW-1:0] ram_lat;
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wren) ram_mem[ram_addr] <= ram_wr_data;
            else          ram_lat <= ram_mem[ram_addr];
        end
        ram_rd_data <= ram_lat;
    end

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            id;
        logic [DW-1:0] data;
    } rsp_t;

    logic [DW-1:0] shadow [1<<AW];
    rsp_t          rq[$];
    int            m_owner = -1;   // -1: no grant held
    int            m_last  = N-1;  // requester served most recently
    int            m_beats = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : compare
        logic [N-1:0]    e_ready, e_rsp, tv, tw, tl;
        logic            e_ce, e_wren, e_busy, o_v, o_w, o_l;
        logic [AW-1:0]   e_addr, o_a;
        logic [DW-1:0]   e_wd, e_rd, o_d;
        logic [N*AW-1:0] ta;
        logic [N*DW-1:0] td;
        int              c;
        rsp_t            r;
        e_ready = '0; e_rsp = '0; e_ce = 1'b0; e_wren = 1'b0; e_busy = 1'b0;
        e_addr = '0; e_wd = '0; e_rd = '0;
        o_v = 1'b0; o_w = 1'b0; o_l = 1'b0; o_a = '0; o_d = '0;
        if (m_owner >= 0) begin
            tv = req_valid >> m_owner; o_v = tv[0];
            tw = req_wren  >> m_owner; o_w = tw[0];
            tl = req_last  >> m_owner; o_l = tl[0];
            ta = req_addr  >> (m_owner * AW); o_a = ta[AW-1:0];
            td = req_wdata >> (m_owner * DW); o_d = td[DW-1:0];
        end
        if (rst_n) begin
            if (m_owner >= 0 && o_v) begin
                e_ready = N'(1) << m_owner;
                e_ce    = 1'b1;
                e_wren  = o_w;
                e_addr  = o_a;
                e_wd    = o_d;
            end
            if (rq.size() > 0 && rq[0].due == cyc) begin
                e_rsp = N'(1) << rq[0].id;
                e_rd  = rq[0].data;
            end
            e_busy = (m_owner >= 0) || (rq.size() > 0);
        end
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        chk("ram_ce", 32'(ram_ce), 32'(e_ce));
        chk("ram_wren", 32'(ram_wren), 32'(e_wren));
        chk("ram_addr", 32'(ram_addr), 32'(e_addr));
        chk("ram_wr_data", 32'(ram_wr_data), 32'(e_wd));
        chk("busy", 32'(busy), 32'(e_busy));
        if (e_rsp != '0) chk("rsp_rdata", 32'(rsp_rdata), 32'(e_rd));
        // Advance the model to the next cycle.
        if (!rst_n) begin
            m_owner = -1;
            m_last  = N - 1;
            m_beats = 0;
            rq.delete();
        end else begin
            if (rq.size() > 0 && rq[0].due == cyc) void'(rq.pop_front());
            if (m_owner < 0) begin
                for (int k = 1; k <= N; k++) begin
                    c  = (m_last + k) % N;
                    tv = req_valid >> c;
                    if (m_owner < 0 && tv[0]) begin
                        m_owner = c;
                        m_beats = 0;
                    end
                end
            end else if (!o_v) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_beats++;
                if (o_w) begin
                    shadow[o_a] = o_d;
                end else begin
                    r.due  = cyc + LAT;
                    r.id   = m_owner;
                    r.data = shadow[o_a];
                    rq.push_back(r);
                end
                if (o_l || m_beats == MAXB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    logic [N-1:0] rr_exp [10] = '{4'h0, 4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h1};
    int           runs [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req_valid = '0;
        req_wren  = '0;
        req_last  = '0;
    endtask

    initial begin
        int run, nruns, n1, nw;
        rst_n = 1'b0;
        idle_all();
        ram_lat     = '0;
        ram_rd_data = '0;
        for (int i = 0; i < N; i++) begin
            a_addr[i]  = '0;
            a_wdata[i] = '0;
        end
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = DW'(i * 37 + 11);
            shadow[i]  = DW'(i * 37 + 11);
        end
        ram_mem[5] = 16'h1234;
        shadow[5]  = 16'h1234;

        // Reset held with every requester asking.
        req_valid = '1;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ce", 32'(ram_ce), 32'h0);
        tick();
        rst_n = 1'b1;
        idle_all();
        tick();
        tick();

        // Single read by requester 0.
        a_addr[0] = 7'h05; req_last = 4'b0001; req_valid = 4'b0001;
        tick();
        @(negedge clk);
        chk("single_ready", 32'(req_ready), 32'h1);
        chk("single_addr", 32'(ram_addr), 32'h5);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("single_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("single_rsp_rdata", 32'(rsp_rdata), 32'h1234);
        tick();
        tick();

        // Round-robin from reset: 0,1,2,3,0 with a bubble between grants.
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < N; i++) a_addr[i] = AW'(i + 8);
        req_wren = '0; req_last = '1; req_valid = '1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("rr_order", 32'(req_ready), 32'(rr_exp[k]));
            tick();
        end
        idle_all();
        repeat (4) tick();

        // Burst cap: requester 2 streams 20 writes, requester 1 reads in between.
        run = 0; nruns = 0; n1 = 0; nw = 0;
        a_addr[1] = 7'h09;
        req_wren = 4'b0100; req_last = 4'b0010; req_valid = 4'b0110;
        for (int k = 0; k < 30; k++) begin
            if (k == 29) req_valid = '0;
            a_addr[2]  = AW'(7'h40 + k);
            a_wdata[2] = DW'($urandom);
            @(negedge clk);
            if (req_ready[2]) run++;
            else if (run > 0) begin
                if (nruns < 4) runs[nruns] = run;
                nruns++;
                run = 0;
            end
            if (req_ready[1]) n1++;
            if (ram_wren) nw++;
            tick();
        end
        chk("burst_nruns", 32'(nruns), 32'd3);
        chk("burst_run0", 32'(runs[0]), 32'd8);
        chk("burst_run1", 32'(runs[1]), 32'd8);
        chk("burst_run2", 32'(runs[2]), 32'd4);
        chk("burst_req1_beats", 32'(n1), 32'd3);
        chk("burst_writes", 32'(nw), 32'd20);
        idle_all();
        repeat (3) tick();

        // Requester 1 drops valid mid-burst; it then goes last in rotation.
        n1 = 0;
        a_addr[1] = 7'h0A; req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (req_ready[1]) n1++;
            tick();
        end
        chk("drop_req1_beats", 32'(n1), 32'd3);
        req_valid = '0;
        @(negedge clk);
        chk("drop_ready_low", 32'(req_ready), 32'h0);
        tick();
        req_valid = '1; req_last = '1;
        @(negedge clk);
        chk("drop_bubble", 32'(req_ready), 32'h0);
        tick();
        @(negedge clk);
        chk("drop_next_owner", 32'(req_ready), 32'h4);
        tick();
        idle_all();
        repeat (3) tick();
        a_addr[1] = 7'h05; req_last = 4'b0010; req_valid = 4'b0010;
        tick();
        @(negedge clk);
        chk("drop_read_ready", 32'(req_ready), 32'h2);
        tick();
        req_valid = '0;
        tick();
        @(negedge clk);
        chk("drop_read_rsp", 32'(rsp_valid), 32'h2);
        chk("drop_read_data", 32'(rsp_rdata), 32'h1234);
        repeat (3) tick();

        // Reset lands one cycle after a read is accepted.
        a_addr[0] = 7'h05; req_last = 4'b0001; req_valid = 4'b0001;
        tick();
        @(negedge clk);
        chk("rstrd_ready", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrd_no_rsp", 32'(rsp_valid), 32'h0);
        chk("rstrd_busy", 32'(busy), 32'h0);
        tick();
        @(negedge clk);
        chk("rstrd_no_rsp_late", 32'(rsp_valid), 32'h0);
        tick();

        // Random traffic.
        for (int t = 0; t < 3000; t++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) req_valid[i] = ~req_valid[i];
                req_wren[i] = 1'($urandom_range(0, 1));
                req_last[i] = ($urandom_range(0, 3) == 0);
                a_addr[i]   = AW'($urandom_range(0, 15));
                a_wdata[i]  = DW'($urandom);
            end
            tick();
        end
        rst_n = 1'b1;
        idle_all();
        repeat (6) tick();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
